serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, >= 1.
REQ-002 Parameter DIGIT, default 2: bits processed per cycle, 1 <= DIGIT <= WIDTH, WIDTH divisible by DIGIT; N = WIDTH/DIGIT.
REQ-003 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  operands present on i_op1, i_op2 and i_borrow.
REQ-006 i_op1  input  WIDTH  minuend.
REQ-007 i_op2  input  WIDTH  subtrahend.
REQ-008 i_borrow  input  1  borrow-in to bit 0.
REQ-009 o_ready  output  1  block can accept a new operation.
REQ-010 o_valid  output  1  o_res and o_borrow hold a completed result.
REQ-011 i_ready  input  1  consumer accepts the result.
REQ-012 o_res  output  WIDTH  difference i_op1 - i_op2 - i_borrow, modulo 2^WIDTH.
REQ-013 o_borrow  output  1  borrow-out of bit WIDTH-1.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 o_ready SHALL be 1 only in IDLE; o_valid SHALL be 1 only in DONE.
REQ-016 Acceptance SHALL occur on a rising edge with IDLE and i_valid=1; i_op1, i_op2 and i_borrow SHALL be registered at that edge, and the FSM SHALL move to CALC with digit counter 0.
REQ-017 Operand input changes after acceptance SHALL have no effect on the result.
REQ-018 i_valid SHALL be ignored in CALC and DONE.
REQ-019 Each CALC edge SHALL subtract one DIGIT-bit slice, LSB slice first, using the borrow registered from the previous slice (i_borrow for slice 0), and store the slice result.
REQ-020 The FSM SHALL move from CALC to DONE on the edge that processes slice N-1; o_valid SHALL rise exactly N cycles after the acceptance edge (DIGIT=WIDTH gives 1 cycle).
REQ-021 The result SHALL be bit-identical to a full-width ripple-borrow subtraction: o_res = (i_op1 - i_op2 - i_borrow) mod 2^WIDTH, o_borrow = 1 if i_op1 < i_op2 + i_borrow.
REQ-022 In DONE, o_res, o_borrow and o_valid SHALL be held stable until an edge with i_ready=1; that edge SHALL move the FSM to IDLE.
REQ-023 There SHALL be no same-cycle DONE->accept bypass; a new operation can be accepted at the earliest one cycle after result handoff.
REQ-024 o_res and o_borrow SHALL stay at their last values in IDLE and CALC until overwritten at the transition to DONE.

Reset
REQ-025 With i_rst=1 at an edge, the FSM SHALL go to IDLE and o_valid, o_res, o_borrow, the digit counter and the borrow register SHALL be set to 0; o_ready SHALL be 1 after that edge.
REQ-026 Reset in CALC or DONE SHALL abort the operation with no result delivered; i_rst SHALL take priority over i_valid and i_ready.

Configuration
REQ-027 Macro SERIAL_SUB_OVERFLOW_EN: when defined, output o_overflow (1 bit) SHALL exist, valid with o_valid, equal to the two's-complement signed overflow of i_op1 - i_op2 - i_borrow, reset to 0, held like o_res.
REQ-028 Without SERIAL_SUB_OVERFLOW_EN, the o_overflow port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification (WIDTH=8, DIGIT=2 unless noted)
REQ-029 0x05 - 0x03 with borrow-in 0 and i_ready=1 -> o_valid rises 4 cycles after acceptance; o_res=0x02, o_borrow=0; o_ready returns to 1 one cycle later.
REQ-030 0x00 - 0x01 with borrow-in 0 -> o_res=0xFF, o_borrow=1; with macro, 0x80 - 0x01 -> o_res=0x7F, o_overflow=1.
REQ-031 Hold i_ready=0 for 5 cycles in DONE, and toggle i_valid/operands during CALC -> the result stays stable with o_valid=1 and o_ready=0; a second operation is not accepted until after handoff.
REQ-032 Assert i_rst on the 2nd CALC cycle -> next cycle IDLE, o_valid=0, o_res=0, o_borrow=0, o_ready=1; a following 0x10 - 0x01 yields 0x0F.
REQ-033 Exhaustive sweep over all op1/op2 pairs with borrow-in 0 and 1, for WIDTH=4 with DIGIT=1, 2 and 4 -> zero mismatches against (op1 - op2 - bin) and borrow flag; latency equals N in every case.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: DIGIT bits per cycle, LSB slice first, ready/valid on both sides.
// Optional o_overflow port is built when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_borrow,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [DIGIT:0]   slice;

  // Top bit of the widened slice difference is the borrow out of that slice.
  assign slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    brw_d   = brw_q;
    res_d   = res_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (i_valid) begin
        state_d = CALC;
        cnt_d   = '0;
        a_d     = i_op1;
        b_d     = i_op2;
        brw_d   = i_borrow;
        acc_d   = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        sa_d    = i_op1[WIDTH-1];
        sb_d    = i_op2[WIDTH-1];
`endif
      end
      CALC: begin
        // Operands shift down; slice results enter the accumulator from the top.
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = slice[DIGIT];
        acc_d = (acc_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = acc_d;
          bout_d  = slice[DIGIT];
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d   = (sa_q ^ sb_q) & (acc_d[WIDTH-1] ^ sa_q);
`endif
        end
      end
      DONE: if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_res    = res_q;
  assign o_borrow = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: one 8/2 instance plus 4-bit instances with DIGIT 1, 2, 4.
// Expectations come from integer arithmetic; a monitor pops them on each result handoff.
module tb_serial_subtractor;

  typedef struct {
    int         dut;
    logic [7:0] res;
    logic       bo;
    logic       ov;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld_i [4];
  logic [7:0] op1   [4];
  logic [7:0] op2   [4];
  logic       bin_i [4];
  logic       rdy_i [4];
  logic       vld_o [4];
  logic       rdy_o [4];
  logic       bo_o  [4];
  logic [7:0] res_o [4];
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ov_o  [4];
`endif

  int   cyc = 0;
  int   mode = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   seen = 0;
  int   expect_rdy = -1;
  bit   stop = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: 0 = always, 1 = random, 2 = held low.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 4; d++)
      rdy_i[d] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld_i[0]), .i_op1(op1[0]), .i_op2(op2[0]),
    .i_borrow(bin_i[0]), .o_ready(rdy_o[0]), .o_valid(vld_o[0]), .i_ready(rdy_i[0]),
    .o_res(res_o[0]), .o_borrow(bo_o[0])
`ifdef SERIAL_SUB_OVERFLOW_EN
    , .o_overflow(ov_o[0])
`endif
  );

  genvar g;
  generate
    for (g = 1; g < 4; g++) begin : g_w4
      logic [3:0] r4;
      serial_subtractor #(.WIDTH(4), .DIGIT((g == 1) ? 1 : (g == 2) ? 2 : 4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_valid(vld_i[g]), .i_op1(op1[g][3:0]), .i_op2(op2[g][3:0]),
        .i_borrow(bin_i[g]), .o_ready(rdy_o[g]), .o_valid(vld_o[g]), .i_ready(rdy_i[g]),
        .o_res(r4), .o_borrow(bo_o[g])
`ifdef SERIAL_SUB_OVERFLOW_EN
        , .o_overflow(ov_o[g])
`endif
      );
      assign res_o[g] = {4'h0, r4};
    end
  endgenerate

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 4 : (d == 2) ? 2 : 1;
  endfunction

  function automatic exp_t model(input int d, input int a, input int b, input int c);
    exp_t e;
    int w, m, diff, sa, sb, sd;
    w    = (d == 0) ? 8 : 4;
    m    = 1 << w;
    diff = a - b - c;
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    sd   = sa - sb - c;
    e.dut = d;
    e.res = 8'(((diff % m) + m) % m);
    e.bo  = (a < b + c);
    e.ov  = (sd < -(m / 2)) || (sd > m / 2 - 1);
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input int d, input int a, input int b, input int c);
    exp_t e;
    int   t;
    vld_i[d] = 1'b1;
    op1[d]   = 8'(a);
    op2[d]   = 8'(b);
    bin_i[d] = 1'(c);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy_o[d] && t < 100);
    if (!rdy_o[d]) chk("accept_timeout", 32'(rdy_o[d]), 32'd1);
    e = model(d, a, b, c);
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the result must not follow them.
    vld_i[d] = 1'b0;
    op1[d]   = 8'($urandom);
    op2[d]   = 8'($urandom);
    bin_i[d] = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    while (!stop) begin
      @(negedge clk);
      if (expect_rdy >= 0) begin
        chk("ready_after_handoff", 32'(rdy_o[expect_rdy]), 32'd1);
        expect_rdy = -1;
      end
      for (int d = 0; d < 4; d++) begin
        if (vld_o[d] === 1'b1) begin
          if (q.size() == 0 || q[0].dut != d) begin
            chk("unexpected_valid", 32'(d), 32'(-1));
          end else begin
            e = q[0];
            if (seen == 0) begin
              seen = 1;
              chk("latency", 32'(cyc - e.acc), 32'(n_of(d)));
            end
            chk("res", 32'(res_o[d]), 32'(e.res));
            chk("borrow", 32'(bo_o[d]), 32'(e.bo));
            chk("ready_low_in_done", 32'(rdy_o[d]), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("overflow", 32'(ov_o[d]), 32'(e.ov));
`endif
            if (rdy_i[d]) begin
              void'(q.pop_front());
              seen = 0;
              expect_rdy = d;
            end
          end
        end
      end
    end
  endtask

  task automatic stimulus();
    exp_t e;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      vld_i[d] = 1'b0; op1[d] = '0; op2[d] = '0; bin_i[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rdy_o[0]), 32'd1);
    chk("rst_valid", 32'(vld_o[0]), 32'd0);
    chk("rst_res", 32'(res_o[0]), 32'd0);
    chk("rst_borrow", 32'(bo_o[0]), 32'd0);
    @(posedge clk);
    #1;

    mode = 0;
    send(0, 8'h05, 8'h03, 0);
    drain();
    send(0, 8'h00, 8'h01, 0);
    send(0, 8'h80, 8'h01, 0);
    send(0, 8'hFF, 8'hFF, 1);
    drain();

    // Stalled consumer while the producer keeps pushing new operands.
    mode = 2;
    e = model(0, 8'hA5, 8'h3C, 1);
    send(0, 8'hA5, 8'h3C, 1);
    repeat (10) begin
      vld_i[0] = 1'b1;
      op1[0]   = 8'($urandom);
      op2[0]   = 8'($urandom);
      bin_i[0] = 1'($urandom);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("hold_valid", 32'(vld_o[0]), 32'd1);
    chk("hold_ready", 32'(rdy_o[0]), 32'd0);
    chk("hold_res", 32'(res_o[0]), 32'(e.res));
    @(posedge clk);
    #1;
    mode = 0;
    send(0, 8'h10, 8'h20, 0);
    drain();

    // Reset on the second CALC cycle aborts the operation.
    send(0, 8'h33, 8'h11, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    seen = 0;
    expect_rdy = -1;
    @(negedge clk);
    chk("abort_valid", 32'(vld_o[0]), 32'd0);
    chk("abort_ready", 32'(rdy_o[0]), 32'd1);
    chk("abort_res", 32'(res_o[0]), 32'd0);
    chk("abort_borrow", 32'(bo_o[0]), 32'd0);
    @(posedge clk);
    #1;
    send(0, 8'h10, 8'h01, 0);
    drain();

    mode = 1;
    repeat (40) send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 1)));
    drain();

    mode = 0;
    for (int d = 1; d < 4; d++) begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          for (int c = 0; c < 2; c++)
            send(d, a, b, c);
      drain();
    end
    stop = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
